// File: rtl/psum_ofifo.sv
// South-edge output collector: one FIFO per array column with a shared read pointer,
// so each pop returns one aligned row even though columns fill with diagonal skew.
module psum_ofifo #(
    parameter int unsigned col     = 8,
    parameter int unsigned psum_bw = 16,
    parameter int unsigned depth   = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [psum_bw*col-1:0]   in,
    input  logic [col-1:0]           wr,
    input  logic                     rd,
    output logic [psum_bw*col-1:0]   out,
    output logic                     o_valid,
    output logic                     o_ready,
    output logic                     full,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int unsigned AW = $clog2(depth);

    logic [AW:0]              wp_q [col];
    logic [AW:0]              wp_d [col];
    logic [AW:0]              rp_q, rp_d;
    logic [psum_bw*col-1:0]   out_q, out_d;
    logic                     o_valid_q, o_valid_d;
    logic                     overflow_q, overflow_d;
    logic                     underflow_q, underflow_d;

    logic [psum_bw-1:0]       mem_q [col][depth];

    logic [AW:0]              cnt [col];
    logic [col-1:0]           empty;
    logic [col-1:0]           colfull;
    logic [col-1:0]           wr_ok;
    logic [psum_bw*col-1:0]   head_row;
    logic                     pop;

    always_comb begin
        empty    = '0;
        colfull  = '0;
        head_row = '0;
        for (int c = 0; c < col; c++) begin
            cnt[c]     = wp_q[c] - rp_q;
            empty[c]   = (cnt[c] == '0);
            colfull[c] = (cnt[c] == (AW+1)'(depth));
            head_row[psum_bw*c +: psum_bw] = mem_q[c][rp_q[AW-1:0]];
        end
    end

    assign o_ready = &(~empty);
    assign full    = |colfull;
    assign pop     = rd & o_ready;

    always_comb begin
        wr_ok       = '0;
        rp_d        = rp_q + (AW+1)'(pop);
        out_d       = pop ? head_row : out_q;
        o_valid_d   = pop;
        underflow_d = underflow_q | (rd & ~o_ready);
        for (int c = 0; c < col; c++) begin
            // A pop on the same edge frees a slot, so a full column may still accept.
            wr_ok[c] = wr[c] & (~colfull[c] | pop);
            wp_d[c]  = wp_q[c] + (AW+1)'(wr_ok[c]);
        end
        overflow_d = overflow_q | (|(wr & ~wr_ok));
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int c = 0; c < col; c++) begin
                wp_q[c] <= '0;
            end
            rp_q        <= '0;
            out_q       <= '0;
            o_valid_q   <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            for (int c = 0; c < col; c++) begin
                wp_q[c] <= wp_d[c];
            end
            rp_q        <= rp_d;
            out_q       <= out_d;
            o_valid_q   <= o_valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is never cleared; writes during a reset cycle are ignored.
    always_ff @(posedge clk) begin
        for (int c = 0; c < col; c++) begin
            if (reset && wr_ok[c]) begin
                mem_q[c][wp_q[c][AW-1:0]] <= in[psum_bw*c +: psum_bw];
            end
        end
    end

    assign out       = out_q;
    assign o_valid   = o_valid_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_psum_ofifo.sv
// Directed bench for psum_ofifo: reset, skewed fill, full/overflow, write+pop on full,
// underflow and pointer wrap-around.
module tb_psum_ofifo;

    localparam int COL = 8;
    localparam int BW  = 16;
    localparam int DEP = 64;

    logic                clk = 1'b0;
    logic                reset;
    logic [BW*COL-1:0]   in;
    logic [COL-1:0]      wr;
    logic                rd;
    logic [BW*COL-1:0]   out;
    logic                o_valid, o_ready, full, overflow, underflow;

    int total = 0;
    int bad   = 0;

    psum_ofifo #(.col(COL), .psum_bw(BW), .depth(DEP)) dut (
        .clk       (clk),
        .reset     (reset),
        .in        (in),
        .wr        (wr),
        .rd        (rd),
        .out       (out),
        .o_valid   (o_valid),
        .o_ready   (o_ready),
        .full      (full),
        .overflow  (overflow),
        .underflow (underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        wr    = '0;
        rd    = 1'b0;
        step();
        reset = 1'b1;
    endtask

    // Column c, entry k carries {c, k} so any misrouting or reordering is visible.
    function automatic logic [BW*COL-1:0] row(int k);
        logic [BW*COL-1:0] r;
        for (int c = 0; c < COL; c++) begin
            r[BW*c +: BW] = 16'((c << 12) | k);
        end
        return r;
    endfunction

    initial begin
        logic [BW*COL-1:0] skew_row;
        logic [BW*COL-1:0] exp_out;

        // Reset with active strobes that must be ignored.
        reset = 1'b0;
        wr    = 8'hFF;
        rd    = 1'b1;
        in    = {4{32'hDEADBEEF}};
        step();
        step();
        reset = 1'b1;
        wr    = '0;
        rd    = 1'b0;
        check("rst_ready", 128'(o_ready), 128'(0));
        check("rst_full", 128'(full), 128'(0));
        check("rst_valid", 128'(o_valid), 128'(0));
        check("rst_out", 128'(out), 128'(0));
        check("rst_ovf", 128'(overflow), 128'(0));
        check("rst_udf", 128'(underflow), 128'(0));

        // Skewed fill: column c written at cycle c.
        skew_row = '0;
        for (int c = 0; c < COL; c++) begin
            skew_row[BW*c +: BW] = 16'(16'h0100 + c);
        end
        for (int c = 0; c < COL; c++) begin
            in = skew_row;
            wr = 8'(1 << c);
            step();
            check("skew_ready", 128'(o_ready), 128'(c == COL - 1));
        end
        wr = '0;
        rd = 1'b1;
        step();
        check("skew_valid", 128'(o_valid), 128'(1));
        check("skew_out", 128'(out), 128'({16'h0107, 16'h0106, 16'h0105, 16'h0104,
                                           16'h0103, 16'h0102, 16'h0101, 16'h0100}));
        rd = 1'b0;
        step();
        check("skew_pulse", 128'(o_valid), 128'(0));
        check("skew_hold", 128'(out), 128'({16'h0107, 16'h0106, 16'h0105, 16'h0104,
                                            16'h0103, 16'h0102, 16'h0101, 16'h0100}));
        check("skew_empty", 128'(o_ready), 128'(0));

        // Fill column 0 to the brim, then one more write must be dropped.
        do_reset();
        for (int i = 0; i < DEP; i++) begin
            in = row(i);
            wr = 8'h01;
            step();
        end
        check("c0_full", 128'(full), 128'(1));
        check("c0_no_ovf", 128'(overflow), 128'(0));
        in = row(99);
        step();
        check("c0_ovf", 128'(overflow), 128'(1));
        check("c0_still_full", 128'(full), 128'(1));
        for (int i = 0; i < DEP; i++) begin
            in = row(i);
            wr = 8'hFE;
            step();
        end
        wr = '0;
        rd = 1'b1;
        for (int i = 0; i < DEP; i++) begin
            step();
            check("fill_valid", 128'(o_valid), 128'(1));
            check("fill_row", 128'(out), 128'(row(i)));
        end
        rd = 1'b0;
        check("fill_drained", 128'(o_ready), 128'(0));

        // Write and pop together on all-full columns.
        do_reset();
        for (int i = 0; i < DEP; i++) begin
            in = row(i);
            wr = 8'hFF;
            step();
        end
        check("sim_full_pre", 128'(full), 128'(1));
        in = row(200);
        wr = 8'hFF;
        rd = 1'b1;
        step();
        wr = '0;
        rd = 1'b0;
        check("sim_valid", 128'(o_valid), 128'(1));
        check("sim_row", 128'(out), 128'(row(0)));
        check("sim_no_ovf", 128'(overflow), 128'(0));
        check("sim_full", 128'(full), 128'(1));

        // Underflow with column 3 empty.
        do_reset();
        for (int i = 0; i < 2; i++) begin
            in = row(i);
            wr = 8'hF7;
            step();
        end
        wr = '0;
        rd = 1'b1;
        step();
        rd = 1'b0;
        check("udf_valid", 128'(o_valid), 128'(0));
        check("udf_out", 128'(out), 128'(0));
        check("udf_flag", 128'(underflow), 128'(1));
        for (int i = 0; i < 2; i++) begin
            in = row(i);
            wr = 8'h08;
            step();
        end
        wr = '0;
        rd = 1'b1;
        step();
        rd = 1'b0;
        check("udf_next_valid", 128'(o_valid), 128'(1));
        check("udf_next_row", 128'(out), 128'(row(0)));

        // Stream 3*depth rows through, wrapping the pointers several times.
        do_reset();
        in = row(0);
        wr = 8'hFF;
        step();
        for (int k = 1; k < 3 * DEP; k++) begin
            in = row(k);
            rd = 1'b1;
            step();
            check("wrap_valid", 128'(o_valid), 128'(1));
            check("wrap_row", 128'(out), 128'(row(k - 1)));
        end
        wr = '0;
        step();
        check("wrap_last", 128'(out), 128'(row(3 * DEP - 1)));
        rd = 1'b0;
        exp_out = row(3 * DEP - 1);
        step();
        check("wrap_end_valid", 128'(o_valid), 128'(0));
        check("wrap_end_hold", 128'(out), 128'(exp_out));
        check("wrap_end_ready", 128'(o_ready), 128'(0));
        check("wrap_ovf", 128'(overflow), 128'(0));
        check("wrap_udf", 128'(underflow), 128'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
